// File: rtl/vga_pkg.sv
// Shared VGA timing constants and types for the 640x480@60 display path.
// Renderers import this for coordinates and the sync bundle layout.
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int COORD_W    = 10;
  localparam int RENDER_LAT = 2;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

endpackage

// File: rtl/vga_if.sv
// Scan-out bundle from the timing generator to renderers and game logic.
// master drives coordinates and sync; slave consumes them.
interface vga_if;
  import vga_pkg::*;

  coord_t      DrawX;
  coord_t      DrawY;
  logic        hs;
  logic        vs;
  logic        blank;
  logic        sync;
  logic        vblank_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank,
    output sync, vblank_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank,
    input sync, vblank_start, frame_count
  );

endinterface

// File: rtl/sig_delay.sv
// W-bit, D-deep shift register loaded with rst_val_i on reset.
// D=0 degenerates to a wire.
module sig_delay #(
  parameter int W = 1,
  parameter int D = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (D == 0) begin : g_pass
      logic unused;
      assign unused = ^{clk_i, rst_i, rst_val_i};
      assign q_o = d_i;
    end else begin : g_pipe
      logic [W-1:0] q_q [D];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < D; i++) begin
            q_q[i] <= rst_val_i;
          end
        end else begin
          q_q[0] <= d_i;
          for (int i = 1; i < D; i++) begin
            q_q[i] <= q_q[i-1];
          end
        end
      end

      assign q_o = q_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel/line counters, sync decode and frame pulse for the VGA path.
// hs/vs/blank are delayed to align with the renderers' RGB registers.
module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int PIPE_DELAY = vga_pkg::RENDER_LAT
) (
  input logic   vga_clk,
  input logic   reset,
  vga_if.master vga
);
  import vga_pkg::*;

  localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t X_LAST = coord_t'(HT - 1);
  localparam coord_t Y_LAST = coord_t'(VT - 1);
  localparam coord_t X_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t Y_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  coord_t      x_q, x_d;
  coord_t      y_q, y_d;
  logic        vb_q, vb_d;
  logic [15:0] frame_q, frame_d;
  sync_t       raw;
  sync_t       dly;

  always_comb begin
    x_d = x_q + coord_t'(1);
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + coord_t'(1);
    end
    // Pulse and count land together, in the cycle showing (0, V_VISIBLE)
    vb_d    = (x_d == '0) && (y_d == Y_VIS);
    frame_d = frame_q + 16'(vb_d);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      vb_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      vb_q    <= vb_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    raw       = SYNC_IDLE;
    raw.blank = (x_q < X_VIS) && (y_q < Y_VIS);
    raw.hs    = !((x_q >= HS_BEG) && (x_q < HS_END));
    raw.vs    = !((y_q >= VS_BEG) && (y_q < VS_END));
  end

  sig_delay #(
    .W ($bits(sync_t)),
    .D (PIPE_DELAY)
  ) u_dly (
    .clk_i     (vga_clk),
    .rst_i     (reset),
    .rst_val_i (SYNC_IDLE),
    .d_i       (raw),
    .q_o       (dly)
  );

  assign vga.DrawX        = x_q;
  assign vga.DrawY        = y_q;
  assign vga.hs           = dly.hs;
  assign vga.vs           = dly.vs;
  assign vga.blank        = dly.blank;
  assign vga.sync         = 1'b0;
  assign vga.vblank_start = vb_q;
  assign vga.frame_count  = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: a shrunken-timing instance plus a default instance, both
// compared every cycle against an arithmetic scan model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vga_if s_if ();
  vga_if d_if ();

  vga_timing_gen #(
    .H_VISIBLE (8),
    .H_FP      (2),
    .H_SYNC    (3),
    .H_BP      (3),
    .V_VISIBLE (6),
    .V_FP      (2),
    .V_SYNC    (2),
    .V_BP      (2),
    .PIPE_DELAY(2)
  ) dut_s (
    .vga_clk (clk),
    .reset   (rst),
    .vga     (s_if)
  );

  vga_timing_gen dut_d (
    .vga_clk (clk),
    .reset   (rst),
    .vga     (d_if)
  );

  typedef struct {
    longint hv, hfp, hs, hbp;
    longint vv, vfp, vs, vbp;
    longint pd;
  } tm_t;

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit bl;
    bit vb;
    int fc;
  } obs_t;

  typedef struct {
    longint t;
    obs_t   e;
  } vec_t;

  tm_t    TS = '{8, 2, 3, 3, 6, 2, 2, 2, 2};
  tm_t    TD = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  int     total = 0;
  int     bad = 0;
  longint t = 0;
  longint fc_off = 0;

  function automatic obs_t model(tm_t m, longint tt, longint off);
    obs_t   o;
    longint ht, vt, ft, p0, td, xx, yy, n;
    ht = m.hv + m.hfp + m.hs + m.hbp;
    vt = m.vv + m.vfp + m.vs + m.vbp;
    ft = ht * vt;
    o.x  = int'(tt % ht);
    o.y  = int'((tt / ht) % vt);
    o.hs = 1'b1;
    o.vs = 1'b1;
    o.bl = 1'b0;
    if (tt >= m.pd) begin
      td = tt - m.pd;
      xx = td % ht;
      yy = (td / ht) % vt;
      o.bl = (xx < m.hv) && (yy < m.vv);
      o.hs = !(xx >= m.hv + m.hfp && xx < m.hv + m.hfp + m.hs);
      o.vs = !(yy >= m.vv + m.vfp && yy < m.vv + m.vfp + m.vs);
    end
    p0   = m.vv * ht;
    o.vb = (tt >= p0) && ((tt - p0) % ft == 0);
    n    = (tt >= p0) ? (tt - p0) / ft + 1 : 0;
    o.fc = int'((n + off) % 65536);
    return o;
  endfunction

  function automatic obs_t samp_s();
    obs_t o;
    o.x  = int'(s_if.DrawX);
    o.y  = int'(s_if.DrawY);
    o.hs = s_if.hs;
    o.vs = s_if.vs;
    o.bl = s_if.blank;
    o.vb = s_if.vblank_start;
    o.fc = int'(s_if.frame_count);
    return o;
  endfunction

  function automatic obs_t samp_d();
    obs_t o;
    o.x  = int'(d_if.DrawX);
    o.y  = int'(d_if.DrawY);
    o.hs = d_if.hs;
    o.vs = d_if.vs;
    o.bl = d_if.blank;
    o.vb = d_if.vblank_start;
    o.fc = int'(d_if.frame_count);
    return o;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", nm, t, act, exp);
    end
  endtask

  task automatic cmp(string tag, obs_t a, obs_t e);
    chk({tag, ".x"}, a.x, e.x);
    chk({tag, ".y"}, a.y, e.y);
    chk({tag, ".hs"}, int'(a.hs), int'(e.hs));
    chk({tag, ".vs"}, int'(a.vs), int'(e.vs));
    chk({tag, ".blank"}, int'(a.bl), int'(e.bl));
    chk({tag, ".vbs"}, int'(a.vb), int'(e.vb));
    chk({tag, ".fc"}, a.fc, e.fc);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      t = 0;
      fc_off = 0;
    end else begin
      t++;
    end
    @(negedge clk);
    cmp("s", samp_s(), model(TS, t, fc_off));
    cmp("d", samp_d(), model(TD, t, 0));
    chk("s.sync", int'(s_if.sync), 0);
    chk("d.sync", int'(d_if.sync), 0);
  endtask

  initial begin
    vec_t   tbl[$];
    int     cnt, cnt2, fx, fy, guard;
    longint pt[$];
    int     pf[$];
    obs_t   o;

    // {t, {x, y, hs, vs, blank, vbs, fc}} for the shrunken timing
    tbl.push_back('{0,   '{0,  0,  1, 1, 0, 0, 0}});
    tbl.push_back('{1,   '{1,  0,  1, 1, 0, 0, 0}});
    tbl.push_back('{2,   '{2,  0,  1, 1, 1, 0, 0}});
    tbl.push_back('{9,   '{9,  0,  1, 1, 1, 0, 0}});
    tbl.push_back('{10,  '{10, 0,  1, 1, 0, 0, 0}});
    tbl.push_back('{12,  '{12, 0,  0, 1, 0, 0, 0}});
    tbl.push_back('{14,  '{14, 0,  0, 1, 0, 0, 0}});
    tbl.push_back('{15,  '{15, 0,  1, 1, 0, 0, 0}});
    tbl.push_back('{16,  '{0,  1,  1, 1, 0, 0, 0}});
    tbl.push_back('{18,  '{2,  1,  1, 1, 1, 0, 0}});
    tbl.push_back('{96,  '{0,  6,  1, 1, 0, 1, 1}});
    tbl.push_back('{97,  '{1,  6,  1, 1, 0, 0, 1}});
    tbl.push_back('{130, '{2,  8,  1, 0, 0, 0, 1}});
    tbl.push_back('{161, '{1,  10, 1, 0, 0, 0, 1}});
    tbl.push_back('{162, '{2,  10, 1, 1, 0, 0, 1}});
    tbl.push_back('{192, '{0,  0,  1, 1, 0, 0, 1}});
    tbl.push_back('{288, '{0,  6,  1, 1, 0, 1, 2}});

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    foreach (tbl[i]) begin
      while (t < tbl[i].t) tick();
      cmp("vec", samp_s(), tbl[i].e);
    end

    // default timing: one whole line of hs
    while (t % 800 != 0) tick();
    cnt = 0;
    fx = -1;
    repeat (800) begin
      tick();
      if (!d_if.hs) begin
        if (cnt == 0) fx = int'(d_if.DrawX);
        cnt++;
      end
    end
    chk("hs_low_cycles", cnt, 96);
    chk("hs_first_x", fx, 658);

    // shrunken timing: one whole frame of vs and blank
    while (t % 192 != 0) tick();
    cnt = 0;
    cnt2 = 0;
    fx = -1;
    fy = -1;
    repeat (192) begin
      tick();
      if (!s_if.vs) begin
        if (cnt == 0) begin
          fx = int'(s_if.DrawX);
          fy = int'(s_if.DrawY);
        end
        cnt++;
      end
      if (s_if.blank) cnt2++;
    end
    chk("vs_low_cycles", cnt, 32);
    chk("vs_first_x", fx, 2);
    chk("vs_first_y", fy, 8);
    chk("blank_per_frame", cnt2, 48);

    // three frames of vblank_start
    repeat (3 * 192) begin
      tick();
      if (s_if.vblank_start) begin
        pt.push_back(t);
        pf.push_back(int'(s_if.frame_count));
        chk("vbs_x", int'(s_if.DrawX), 0);
        chk("vbs_y", int'(s_if.DrawY), 6);
      end
    end
    chk("vbs_pulses", pt.size(), 3);
    for (int i = 1; i < pt.size(); i++) begin
      chk("vbs_gap", int'(pt[i] - pt[i-1]), 192);
      chk("fc_step", pf[i], pf[i-1] + 1);
    end

    // reset in the last visible line, just before vblank
    guard = 0;
    while (!(s_if.DrawX == 10'd5 && s_if.DrawY == 10'd5) && guard < 400) begin
      tick();
      guard++;
    end
    chk("reach_5_5", guard < 400 ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_x", int'(s_if.DrawX), 0);
    chk("rst_y", int'(s_if.DrawY), 0);
    chk("rst_fc", int'(s_if.frame_count), 0);
    chk("rst_vbs", int'(s_if.vblank_start), 0);
    chk("rst_blank0", int'(s_if.blank), 0);
    tick();
    chk("rst_blank1", int'(s_if.blank), 0);
    tick();
    chk("rst_blank2", int'(s_if.blank), 1);

    // frame counter wrap
    while (t < 50) tick();
    force dut_s.frame_q = 16'hFFFF;
    #1;
    release dut_s.frame_q;
    o = model(TS, t, 0);
    fc_off = 65535 - longint'(o.fc);
    chk("fc_forced", int'(s_if.frame_count), 65535);
    while (t < 96) tick();
    chk("fc_wrap", int'(s_if.frame_count), 0);
    chk("fc_wrap_vbs", int'(s_if.vblank_start), 1);
    chk("fc_wrap_y", int'(s_if.DrawY), 6);

    // random run lengths with random resets
    repeat (40) begin
      repeat ($urandom_range(1, 600)) tick();
      if ($urandom_range(0, 1) == 1) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
